// File: rtl/rx_sync_ctrl.sv
// Serial comma-alignment and 4-lane byte sequencer for the PHY receive path.
// Optional slip detection (sync_err) when RX_SLIP_DET_EN is defined.
module rx_sync_ctrl #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         LOCK_CNT = 4
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       val_out0,
  output logic       val_out1,
  output logic       val_out2,
  output logic       val_out3,
  output logic       active,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    SEARCH,
    LOCKING,
    ACTIVE
  } state_t;

  state_t          state, state_n;
  logic [6:0]      shift_reg;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [3:0]      comma_cnt, comma_cnt_n;
  logic [1:0]      lane_ptr, lane_ptr_n;
  logic [3:0][7:0] lanes, lanes_n;
  logic [3:0]      val, val_n;
  logic            sync_err_n;

  logic [7:0] w;
  logic       is_comma;
  logic       boundary;

  // Only the 7 previous bits are kept; the current bit completes the window.
  assign w        = {shift_reg, serial_in};
  assign is_comma = (w == COMMA);
  assign boundary = (bit_cnt == 3'd7);

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt + 3'd1;
    comma_cnt_n = comma_cnt;
    lane_ptr_n  = lane_ptr;
    lanes_n     = lanes;
    val_n       = '0;
    sync_err_n  = 1'b0;
    unique case (state)
      SEARCH: begin
        if (is_comma) begin
          bit_cnt_n   = 3'd0;
          comma_cnt_n = 4'd1;
          state_n     = LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_n = comma_cnt + 4'd1;
            if (comma_cnt_n == LOCK_CNT[3:0]) begin
              state_n    = ACTIVE;
              lane_ptr_n = 2'd0;
            end
          end else begin
            state_n     = SEARCH;
            comma_cnt_n = 4'd0;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          if (is_comma) begin
            lane_ptr_n = 2'd0;
          end else begin
            lanes_n[lane_ptr] = w;
            val_n[lane_ptr]   = 1'b1;
            lane_ptr_n        = lane_ptr + 2'd1;
          end
        end
`ifdef RX_SLIP_DET_EN
        else if (is_comma) begin
          // Comma off the byte grid: alignment lost, drop the partial byte.
          sync_err_n  = 1'b1;
          state_n     = SEARCH;
          comma_cnt_n = 4'd0;
          lane_ptr_n  = 2'd0;
        end
`endif
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      state     <= SEARCH;
      shift_reg <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      lane_ptr  <= '0;
      lanes     <= '0;
      val       <= '0;
      active    <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= w[6:0];
      bit_cnt   <= bit_cnt_n;
      comma_cnt <= comma_cnt_n;
      lane_ptr  <= lane_ptr_n;
      lanes     <= lanes_n;
      val       <= val_n;
      active    <= (state_n == ACTIVE);
      sync_err  <= sync_err_n;
    end
  end

  assign out0     = lanes[0];
  assign out1     = lanes[1];
  assign out2     = lanes[2];
  assign out3     = lanes[3];
  assign val_out0 = val[0];
  assign val_out1 = val[1];
  assign val_out2 = val[2];
  assign val_out3 = val[3];

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Directed bench for rx_sync_ctrl: vector table plus lock/reset/slip sequences.
// Slip expectations follow RX_SLIP_DET_EN.
module tb_rx_sync_ctrl;

  logic       clk_32f = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic       val_out0, val_out1, val_out2, val_out3;
  logic       active, sync_err;

  rx_sync_ctrl dut (
    .clk_32f  (clk_32f),
    .rst      (rst),
    .serial_in(serial_in),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .val_out0 (val_out0),
    .val_out1 (val_out1),
    .val_out2 (val_out2),
    .val_out3 (val_out3),
    .active   (active),
    .sync_err (sync_err)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] data;
    logic [3:0] val;
    logic [1:0] lane;
    logic       act;
  } vec_t;

  vec_t       tab [15];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] vals;
  logic [3:0] mid_val;
  logic       mid_act;
  logic       prev_act;

  assign vals = {val_out3, val_out2, val_out1, val_out0};

  function automatic logic [7:0] lane_out(input logic [1:0] i);
    case (i)
      2'd0: return out0;
      2'd1: return out1;
      2'd2: return out2;
      default: return out3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    mid_val = '0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      mid_val |= vals;
    end
    mid_act = active;
    send_bit(b[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send_bit(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    tab[0]  = '{8'hBC, 4'b0000, 2'd0, 1'b0};
    tab[1]  = '{8'hBC, 4'b0000, 2'd0, 1'b0};
    tab[2]  = '{8'hBC, 4'b0000, 2'd0, 1'b0};
    tab[3]  = '{8'hBC, 4'b0000, 2'd0, 1'b1};
    tab[4]  = '{8'hBD, 4'b0001, 2'd0, 1'b1};
    tab[5]  = '{8'hBD, 4'b0010, 2'd1, 1'b1};
    tab[6]  = '{8'hBA, 4'b0100, 2'd2, 1'b1};
    tab[7]  = '{8'hAB, 4'b1000, 2'd3, 1'b1};
    tab[8]  = '{8'h11, 4'b0001, 2'd0, 1'b1};
    tab[9]  = '{8'h22, 4'b0010, 2'd1, 1'b1};
    tab[10] = '{8'h33, 4'b0100, 2'd2, 1'b1};
    tab[11] = '{8'h44, 4'b1000, 2'd3, 1'b1};
    tab[12] = '{8'h55, 4'b0001, 2'd0, 1'b1};
    tab[13] = '{8'hBC, 4'b0000, 2'd0, 1'b1};
    tab[14] = '{8'h66, 4'b0001, 2'd0, 1'b1};

    // Reset with toggling input
    rst = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    chk("rst_out0", out0, 8'h00);
    chk("rst_out1", out1, 8'h00);
    chk("rst_out2", out2, 8'h00);
    chk("rst_out3", out3, 8'h00);
    chk("rst_val", vals, 4'b0000);
    chk("rst_active", active, 1'b0);
    chk("rst_sync_err", sync_err, 1'b0);
    rst = 1'b0;

    // Lock, lane rotation, wrap and comma delimiter
    prev_act = 1'b0;
    for (int i = 0; i < 15; i++) begin
      send_byte(tab[i].data);
      chk($sformatf("vec%0d_stray_val", i), mid_val, 4'b0000);
      chk($sformatf("vec%0d_act_pre", i), mid_act, prev_act);
      chk($sformatf("vec%0d_val", i), vals, tab[i].val);
      chk($sformatf("vec%0d_active", i), active, tab[i].act);
      if (tab[i].val != 4'b0000)
        chk($sformatf("vec%0d_out", i), lane_out(tab[i].lane), tab[i].data);
      prev_act = tab[i].act;
    end
    send_bit(1'b0);
    chk("pulse_width", vals, 4'b0000);
    chk("hold_out1", out1, 8'h22);
    chk("hold_out2", out2, 8'h33);
    chk("hold_out3", out3, 8'h44);

    // Broken comma run falls back to SEARCH, then needs a full run
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    send_byte(8'h55);
    chk("brk_active", active, 1'b0);
    chk("brk_val", vals | mid_val, 4'b0000);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk("brk_3commas", active, 1'b0);
    send_byte(8'hBC);
    chk("brk_4commas", active, 1'b1);

    // Leading garbage bits before the comma run
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk("garb_3commas", active, 1'b0);
    send_byte(8'hBC);
    chk("garb_active", active, 1'b1);
    send_byte(8'h3C);
    chk("garb_val", vals, 4'b0001);
    chk("garb_out0", out0, 8'h3C);

    // Reset mid-byte while active
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    send_bit(1'b1);
    rst = 1'b0;
    chk("mid_rst_active", active, 1'b0);
    chk("mid_rst_out0", out0, 8'h00);
    chk("mid_rst_val", vals, 4'b0000);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk("relock_3", active, 1'b0);
    send_byte(8'hBC);
    chk("relock_4", active, 1'b1);

    // Comma shifted by 3 bits while active
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 7; i >= 3; i--) send_bit(tab[0].data[i]);
    chk("slip_byte_val", vals, 4'b0001);
    chk("slip_byte_out0", out0, 8'h17);
    for (int i = 2; i >= 0; i--) send_bit(tab[0].data[i]);
`ifdef RX_SLIP_DET_EN
    chk("slip_err", sync_err, 1'b1);
    chk("slip_active", active, 1'b0);
    send_bit(1'b0);
    chk("slip_err_pulse", sync_err, 1'b0);
    chk("slip_active_hold", active, 1'b0);
`else
    chk("slip_err", sync_err, 1'b0);
    chk("slip_active", active, 1'b1);
    send_bit(1'b0);
    chk("slip_err_pulse", sync_err, 1'b0);
    chk("slip_active_hold", active, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
